// File: rtl/jtdd_irqctl.sv
// jtdd_irqctl: interrupt request controller for the sound/main CPUs.
// Each channel is either edge-latched (held until acknowledged) or a
// level pass-through, with selectable polarity, a mask register, a
// sticky overrun flag and a fixed-priority pending index.
module jtdd_irqctl #(
  parameter int             W        = 3,
  parameter logic [W-1:0]   EDGE     = '1,
  parameter logic [W-1:0]   POL      = '0,
  parameter logic [W-1:0]   MASK_RST = '1,
  parameter int             PW       = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [W-1:0]  din,
  input  logic [W-1:0]  clr,
  input  logic [W-1:0]  set,
  input  logic          mask_we,
  input  logic [W-1:0]  mask_din,
  input  logic          pause,
  output logic [W-1:0]  q,
  output logic [W-1:0]  qn,
  output logic          irq_any,
  output logic [PW-1:0] pend,
  output logic [W-1:0]  lost
);

  // Sources normalised so that 1 always means "asserted".
  logic [W-1:0] s;
  // Previous sample of s, used to detect rising transitions.
  logic [W-1:0] prev;
  // One-clock edge events, only meaningful on edge-mode channels.
  logic [W-1:0] e;
  // Anything that should (re)latch an edge-mode channel this clock.
  logic [W-1:0] hit;
  // Registered latch for edge-mode channels.
  logic [W-1:0] lat_r;
  // Effective request per channel, before the mask.
  logic [W-1:0] lat;
  // Channel enable register.
  logic [W-1:0] mask;
  // Sticky overrun flags.
  logic [W-1:0] lost_r;

  assign s   = din ^ POL;
  assign e   = {W{cen & ~pause}} & s & ~prev & EDGE;
  assign hit = (e | set) & EDGE;

  // Track the qualified source; loading s during reset means a source
  // already asserted when reset lifts is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= s;
    end else if (cen) begin
      prev <= s;
    end
  end

  // Edge latches: a new edge or software set beats an acknowledge on the
  // same clock, so a request arriving during the ack is never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_r <= '0;
    end else begin
      lat_r <= ((lat_r & ~clr) | hit) & EDGE;
    end
  end

  // Overrun flags: raised when a channel is hit while still latched and
  // not being acknowledged; an acknowledge always clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_r <= '0;
    end else begin
      lost_r <= ((lost_r & ~clr) | (hit & lat_r & ~clr)) & EDGE;
    end
  end

  // Mask register; writes ignore cen so the CPU can always reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_din;
    end
  end

  // Edge channels use the latch, level channels follow the source live.
  always_comb begin
    lat = (lat_r & EDGE) | ((s | set) & ~EDGE);
  end

  // Masked requests; held low while in reset so level channels cannot
  // leak through before the controller is released.
  always_comb begin
    q = rst ? '0 : (lat & mask);
  end

  // Active-low copy and summary for the CPU interrupt pins.
  always_comb begin
    qn      = ~q;
    irq_any = |q;
    lost    = lost_r;
  end

  // Fixed-priority encode: scanning downwards lets the lowest set
  // channel have the final say.
  always_comb begin
    pend = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (q[i]) pend = PW'(i);
    end
  end

endmodule

// File: tb/tb_jtdd_irqctl.sv
// tb_jtdd_irqctl: directed checks of jtdd_irqctl in its default 3-channel
// edge configuration and in a 2-channel mixed edge/level, mixed polarity
// configuration.
module tb_jtdd_irqctl;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Default instance: W=3, all edge, rising, mask reset all ones.
  logic       a_rst, a_cen, a_mask_we, a_pause;
  logic [2:0] a_din, a_clr, a_set, a_mask_din;
  logic [2:0] a_q, a_qn, a_lost;
  logic       a_irq_any;
  logic [1:0] a_pend;

  // Mixed instance: ch0 edge rising, ch1 level active-low.
  logic       b_rst, b_cen, b_mask_we, b_pause;
  logic [1:0] b_din, b_clr, b_set, b_mask_din;
  logic [1:0] b_q, b_qn, b_lost;
  logic       b_irq_any;
  logic [0:0] b_pend;

  jtdd_irqctl dut_a (
    .clk(clk), .rst(a_rst), .cen(a_cen), .din(a_din), .clr(a_clr),
    .set(a_set), .mask_we(a_mask_we), .mask_din(a_mask_din),
    .pause(a_pause), .q(a_q), .qn(a_qn), .irq_any(a_irq_any),
    .pend(a_pend), .lost(a_lost)
  );

  jtdd_irqctl #(.W(2), .EDGE(2'b01), .POL(2'b10), .MASK_RST(2'b11)) dut_b (
    .clk(clk), .rst(b_rst), .cen(b_cen), .din(b_din), .clr(b_clr),
    .set(b_set), .mask_we(b_mask_we), .mask_din(b_mask_din),
    .pause(b_pause), .q(b_q), .qn(b_qn), .irq_any(b_irq_any),
    .pend(b_pend), .lost(b_lost)
  );

  always #5 clk = ~clk;

  // Drive every input of the default instance, then advance one clock and
  // settle just past the edge.
  task automatic applyStimulus(input logic [2:0] d, input logic [2:0] c,
                               input logic [2:0] s, input logic mwe,
                               input logic [2:0] md, input logic p,
                               input logic ce);
    a_din      = d;
    a_clr      = c;
    a_set      = s;
    a_mask_we  = mwe;
    a_mask_din = md;
    a_pause    = p;
    a_cen      = ce;
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    a_rst = 1'b1;
    b_rst = 1'b1; b_cen = 1'b1; b_pause = 1'b0; b_set = '0; b_clr = '0;
    b_mask_we = 1'b0; b_mask_din = '0; b_din = 2'b10;
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b000, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1);
    // Reset state; set/clr/mask_we are asserted too and must be ignored.
    checkOutput("rst_q",    32'(a_q), 32'h0);
    checkOutput("rst_qn",   32'(a_qn), 32'h7);
    checkOutput("rst_any",  32'(a_irq_any), 32'h0);
    checkOutput("rst_pend", 32'(a_pend), 32'h0);
    checkOutput("rst_lost", 32'(a_lost), 32'h0);
    checkOutput("b_rst_q",  32'(b_q), 32'h0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("post_rst_q", 32'(a_q), 32'h0);

    // Basic edge capture and acknowledge.
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("edge0_q",    32'(a_q), 32'h1);
    checkOutput("edge0_qn",   32'(a_qn), 32'h6);
    checkOutput("edge0_pend", 32'(a_pend), 32'h0);
    checkOutput("edge0_any",  32'(a_irq_any), 32'h1);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("clr0_q", 32'(a_q), 32'h0);

    // Overrun, then acknowledge colliding with a fresh edge.
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("lost_pre", 32'(a_lost), 32'h0);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("lost_set", 32'(a_lost), 32'h1);
    checkOutput("lost_q",   32'(a_q), 32'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("clr_edge_q",    32'(a_q), 32'h1);
    checkOutput("clr_edge_lost", 32'(a_lost), 32'h0);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("clr_again_q", 32'(a_q), 32'h0);

    // Pause hides the edge, and releasing it does not replay the edge.
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1);
    applyStimulus(3'b011, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1);
    checkOutput("pause_q", 32'(a_q), 32'h0);
    applyStimulus(3'b011, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("unpause_q", 32'(a_q), 32'h0);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b011, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("retoggle_q", 32'(a_q), 32'h2);
    checkOutput("retoggle_pend", 32'(a_pend), 32'h1);
    applyStimulus(3'b011, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

    // Masked channel still latches and appears once unmasked.
    applyStimulus(3'b011, 3'b000, 3'b000, 1'b1, 3'b011, 1'b0, 1'b1);
    applyStimulus(3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("masked_q",   32'(a_q), 32'h0);
    checkOutput("masked_any", 32'(a_irq_any), 32'h0);
    applyStimulus(3'b111, 3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b1);
    checkOutput("unmask_q",    32'(a_q), 32'h4);
    checkOutput("unmask_pend", 32'(a_pend), 32'h2);
    applyStimulus(3'b111, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

    // Software set of all channels and priority walk-down.
    applyStimulus(3'b111, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("setall_q",    32'(a_q), 32'h7);
    checkOutput("setall_pend", 32'(a_pend), 32'h0);
    checkOutput("setall_lost", 32'(a_lost), 32'h0);
    applyStimulus(3'b111, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("walk1_pend", 32'(a_pend), 32'h1);
    applyStimulus(3'b111, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("walk2_pend", 32'(a_pend), 32'h2);
    applyStimulus(3'b111, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("walk3_any", 32'(a_irq_any), 32'h0);

    // Clock enable low: no capture, but set still acts.
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b001, 3'b000, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("cen0_q", 32'(a_q), 32'h2);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("cen1_q", 32'(a_q), 32'h3);
    applyStimulus(3'b001, 3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("cen_clr_q", 32'(a_q), 32'h0);

    // Reset mid-request drops it, restores the mask, and raises no event.
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("pre_rst_q", 32'(a_q), 32'h1);
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1);
    a_rst = 1'b1;
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    a_rst = 1'b0;
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("rst_drop_q", 32'(a_q), 32'h0);
    applyStimulus(3'b001, 3'b000, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("rst_mask_q", 32'(a_q), 32'h1);

    // Mixed instance: level channel 1 is active-low and immediate.
    b_din = 2'b10;
    #1;
    checkOutput("b_idle_q", 32'(b_q), 32'h0);
    b_din = 2'b00;
    #1;
    checkOutput("b_level_q",    32'(b_q), 32'h2);
    checkOutput("b_level_pend", 32'(b_pend), 32'h1);
    b_clr = 2'b10;
    @(posedge clk);
    #1;
    b_clr = 2'b00;
    checkOutput("b_clr_q",    32'(b_q), 32'h2);
    checkOutput("b_clr_lost", 32'(b_lost), 32'h0);
    b_din = 2'b10;
    #1;
    checkOutput("b_release_q", 32'(b_q), 32'h0);
    b_din = 2'b11;
    b_rst = 1'b1;
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("b_rst_noevt_q", 32'(b_q), 32'h0);
    b_din = 2'b10;
    @(posedge clk);
    #1;
    b_din = 2'b11;
    @(posedge clk);
    #1;
    checkOutput("b_edge_q",    32'(b_q), 32'h1);
    checkOutput("b_edge_pend", 32'(b_pend), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
